// File: rtl/snake_pkg.sv
// Shared definitions for the snake game front end.
//   KEY_*            : keypad codes (row_idx*4 + col_idx) used by the game logic
//   debounce_state_t : state encoding for the keypad debounce FSM
package snake_pkg;

  localparam logic [3:0] KEY_LEFT  = 4'd2;
  localparam logic [3:0] KEY_DOWN  = 4'd3;
  localparam logic [3:0] KEY_RIGHT = 4'd4;
  localparam logic [3:0] KEY_UP    = 4'd7;

  typedef enum logic [1:0] {
    IDLE,
    PCAND,
    HELD,
    RCAND
  } debounce_state_t;

endpackage

// File: rtl/keypad_debounce_fsm.sv
// Frame-level debounce FSM for the keypad scanner.
//   clk, rst       : clock, asynchronous active-low reset
//   eval           : one-cycle strobe, a complete scan frame result is present
//   frame_valid    : the frame found a key
//   frame_code     : priority key code of the frame (meaningful when frame_valid)
//   code           : accepted key code, held after release
//   key_valid      : high while the accepted key is held
//   key_press      : one-cycle strobe on accepted press
//   key_release    : one-cycle strobe on accepted release
module keypad_debounce_fsm
  import snake_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       eval,
  input  logic       frame_valid,
  input  logic [3:0] frame_code,
  output logic [3:0] code,
  output logic       key_valid,
  output logic       key_press,
  output logic       key_release
);

  localparam logic [3:0] FRAMES = 4'(DEBOUNCE_FRAMES);

  debounce_state_t state, state_n;
  logic [3:0] cand, cand_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] cnt_inc;
  logic [3:0] code_n;
  logic       valid_n, press_n, release_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cand        <= '0;
      cnt         <= '0;
      code        <= '0;
      key_valid   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= state_n;
      cand        <= cand_n;
      cnt         <= cnt_n;
      code        <= code_n;
      key_valid   <= valid_n;
      key_press   <= press_n;
      key_release <= release_n;
    end
  end

  // cnt never exceeds FRAMES-1 while a candidate is pending, so the
  // increment cannot overflow; reaching FRAMES always leaves the state.
  assign cnt_inc = cnt + 4'd1;

  always_comb begin
    state_n   = state;
    cand_n    = cand;
    cnt_n     = cnt;
    code_n    = code;
    valid_n   = key_valid;
    press_n   = 1'b0;
    release_n = 1'b0;

    if (eval) begin
      unique case (state)
        IDLE: begin
          if (frame_valid) begin
            // With a single-frame requirement the entering frame already accepts.
            if (FRAMES == 4'd1) begin
              state_n = HELD;
              code_n  = frame_code;
              valid_n = 1'b1;
              press_n = 1'b1;
              cnt_n   = '0;
            end else begin
              state_n = PCAND;
              cand_n  = frame_code;
              cnt_n   = 4'd1;
            end
          end
        end

        PCAND: begin
          if (!frame_valid) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if (frame_code == cand) begin
            if (cnt_inc == FRAMES) begin
              state_n = HELD;
              code_n  = cand;
              valid_n = 1'b1;
              press_n = 1'b1;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            cand_n = frame_code;
            cnt_n  = 4'd1;
          end
        end

        HELD: begin
          if (!(frame_valid && frame_code == code)) begin
            if (FRAMES == 4'd1) begin
              state_n   = IDLE;
              valid_n   = 1'b0;
              release_n = 1'b1;
              cnt_n     = '0;
            end else begin
              state_n = RCAND;
              cnt_n   = 4'd1;
            end
          end
        end

        RCAND: begin
          if (frame_valid && frame_code == code) begin
            state_n = HELD;
            cnt_n   = '0;
          end else if (cnt_inc == FRAMES) begin
            state_n   = IDLE;
            valid_n   = 1'b0;
            release_n = 1'b1;
            cnt_n     = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end

        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner with frame-based debounce.
//   clk, rst    : clock, asynchronous active-low reset
//   row         : keypad rows, active-low (pulled up externally)
//   col         : column drive, active-low one-hot
//   code        : accepted key code (row_idx*4 + col_idx), held after release
//   key_valid   : high while the accepted key is held
//   key_press   : one-cycle strobe on accepted press
//   key_release : one-cycle strobe on accepted release
//   scan_tick   : one-cycle strobe coinciding with every column change
module keypad_scan_debounce
  import snake_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 25000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] code,
  output logic       key_valid,
  output logic       key_press,
  output logic       key_release,
  output logic       scan_tick
);

  localparam int unsigned DW = $clog2(SCAN_DIV);

  logic [3:0]    row_s1, row_s2;
  logic [DW-1:0] dwell;
  logic [1:0]    col_idx;
  logic          last_dwell;

  logic          found;
  logic [3:0]    found_code;
  logic          sample_hit;
  logic [1:0]    sample_row;

  logic          eval;
  logic          frame_valid;
  logic [3:0]    frame_code;

  // Rows idle high, so the synchroniser resets to all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_s1 <= '1;
      row_s2 <= '1;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
    end
  end

  assign last_dwell = (dwell == DW'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell     <= '0;
      col_idx   <= '0;
      col       <= 4'b1110;
      scan_tick <= 1'b0;
    end else begin
      scan_tick <= last_dwell;
      if (last_dwell) begin
        dwell   <= '0;
        col_idx <= col_idx + 2'd1;
        col     <= ~(4'b0001 << (col_idx + 2'd1));
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end

  // Lowest low row of the current column.
  always_comb begin
    sample_hit = 1'b0;
    sample_row = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      if (!sample_hit && !row_s2[r]) begin
        sample_hit = 1'b1;
        sample_row = 2'(r);
      end
    end
  end

  // The last column of a frame is folded in combinationally so the FSM
  // sees the complete frame on the same cycle it is sampled.
  assign eval        = last_dwell && (col_idx == 2'd3);
  assign frame_valid = found || sample_hit;
  assign frame_code  = found ? found_code : {sample_row, col_idx};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      found      <= 1'b0;
      found_code <= '0;
    end else if (last_dwell) begin
      if (eval) begin
        found      <= 1'b0;
        found_code <= '0;
      end else if (!found && sample_hit) begin
        found      <= 1'b1;
        found_code <= {sample_row, col_idx};
      end
    end
  end

  keypad_debounce_fsm #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_fsm (
    .clk         (clk),
    .rst         (rst),
    .eval        (eval),
    .frame_valid (frame_valid),
    .frame_code  (frame_code),
    .code        (code),
    .key_valid   (key_valid),
    .key_press   (key_press),
    .key_release (key_release)
  );

endmodule

// File: tb/tb_keypad_scan_debounce.sv
module tb_keypad_scan_debounce;
  import snake_pkg::*;

  localparam int unsigned SD = 4;
  localparam int unsigned DF = 3;

  logic       clk;
  logic       rst;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] code;
  logic       key_valid, key_press, key_release, scan_tick;

  logic [15:0] keys;

  int unsigned n_checks;
  int unsigned n_fails;

  // Reference model state
  bit         m_held;
  logic [3:0] m_code;
  bit         m_run_valid;
  logic [3:0] m_run_key;
  int         m_run_len;
  int         m_miss;

  keypad_scan_debounce #(
    .SCAN_DIV        (SD),
    .DEBOUNCE_FRAMES (DF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .row         (row),
    .col         (col),
    .code        (code),
    .key_valid   (key_valid),
    .key_press   (key_press),
    .key_release (key_release),
    .scan_tick   (scan_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its row low when its column is driven.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4 + c] && !col[c]) row[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_held = 0; m_code = '0; m_run_valid = 0; m_run_key = '0; m_run_len = 0; m_miss = 0;
  endtask

  // One frame of the reference: priority key from the mask, then the
  // "D consecutive identical frames since the last accept" rule.
  task automatic model_frame(input logic [15:0] mask, output bit press, output bit rel);
    bit         fv;
    logic [3:0] fk;
    fv = 0; fk = '0; press = 0; rel = 0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!fv && mask[r*4 + c]) begin fv = 1; fk = 4'(r*4 + c); end
    if (!m_held) begin
      if (!fv) m_run_len = 0;
      else if (m_run_len > 0 && fk == m_run_key) m_run_len++;
      else begin m_run_key = fk; m_run_len = 1; end
      if (m_run_len == DF) begin
        m_held = 1; m_code = m_run_key; press = 1; m_run_len = 0; m_miss = 0;
      end
    end else begin
      if (fv && fk == m_code) m_miss = 0;
      else m_miss++;
      if (m_miss == DF) begin
        m_held = 0; rel = 1; m_miss = 0; m_run_len = 0;
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #1;
    chk("rst_col", col, 4'b1110);
    chk("rst_code", code, 4'd0);
    chk("rst_valid", {3'b0, key_valid}, 4'd0);
    chk("rst_press", {3'b0, key_press}, 4'd0);
    chk("rst_release", {3'b0, key_release}, 4'd0);
    chk("rst_tick", {3'b0, scan_tick}, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_clear();
  endtask

  // Called 1 time unit after a frame boundary edge; runs ncyc cycles of a frame.
  task automatic run_frame(input logic [15:0] mask, input int ncyc);
    bit p, r;
    keys = mask;
    p = 0; r = 0;
    for (int j = 1; j <= ncyc; j++) begin
      @(posedge clk);
      #1;
      if (j == 16) model_frame(mask, p, r);
      chk("col", col, ~(4'b0001 << ((j / 4) % 4)));
      chk("scan_tick", {3'b0, scan_tick}, {3'b0, (j % 4) == 0});
      chk("key_valid", {3'b0, key_valid}, {3'b0, m_held});
      chk("code", code, m_code);
      chk("key_press", {3'b0, key_press}, {3'b0, p});
      chk("key_release", {3'b0, key_release}, {3'b0, r});
    end
  endtask

  task automatic frames(input logic [15:0] mask, input int n);
    for (int i = 0; i < n; i++) run_frame(mask, 16);
  endtask

  function automatic logic [15:0] kmask(input logic [3:0] k);
    return 16'd1 << k;
  endfunction

  initial begin
    n_checks = 0;
    n_fails  = 0;
    keys = '0;
    rst  = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    apply_reset();

    // Idle scanning
    frames('0, 3);
    // Clean press/release of key 7
    frames(kmask(KEY_UP), 6);
    frames('0, 4);
    // Bounce on key 4
    frames(kmask(KEY_RIGHT), 2);
    frames('0, 1);
    frames(kmask(KEY_RIGHT), 3);
    frames('0, 4);
    // Two keys, then release the priority one
    frames(kmask(KEY_LEFT) | kmask(KEY_DOWN), 4);
    frames(kmask(KEY_DOWN), 8);
    frames('0, 4);
    // Short release glitch
    frames(kmask(KEY_DOWN), 4);
    frames('0, 2);
    frames(kmask(KEY_DOWN), 3);
    frames('0, 4);
    // Reset while held, then re-acceptance
    frames(kmask(KEY_DOWN), 4);
    run_frame(kmask(KEY_DOWN), 7);
    apply_reset();
    frames(kmask(KEY_DOWN), 4);
    frames('0, 4);

    // Randomised runs of key patterns
    for (int i = 0; i < 40; i++) begin
      logic [15:0] m;
      int unsigned sel;
      sel = $urandom_range(0, 3);
      case (sel)
        0: m = '0;
        1: m = kmask(4'($urandom_range(0, 15)));
        2: m = kmask(4'($urandom_range(0, 15))) | kmask(4'($urandom_range(0, 15)));
        default: m = 16'($urandom);
      endcase
      frames(m, int'($urandom_range(1, 5)));
    end
    frames('0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/keypad_scan_debounce.md
# keypad_scan_debounce

Synchronous 4x4 matrix-keypad scanner and debouncer that drives the keypad columns, samples the rows, and delivers a clean key code to the game logic. It sits directly upstream of the snake control block. It replaces the edge-clocked `keydown` usage with a single-cycle `key_press` strobe in the `clk` domain, and it emits a `scan_tick` strobe for the LED digit multiplexer.

## Interface

Parameters:
- `SCAN_DIV`, 25000: clk cycles each column is driven. Must be ≥ 4.
- `DEBOUNCE_FRAMES`, 4: consecutive identical scan frames required to accept a press or a release. Range 1..15.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `row`, in, 4: keypad rows. Active-low, externally pulled up.
- `col`, out, 4: column drive. Active-low one-hot.
- `code`, out, 4: accepted key code = row_idx*4 + col_idx. Held after release.
- `key_valid`, out, 1: high while the accepted key is held.
- `key_press`, out, 1: 1-cycle strobe when a press is accepted.
- `key_release`, out, 1: 1-cycle strobe when a release is accepted.
- `scan_tick`, out, 1: 1-cycle strobe at every column change.

## Operation

**Row synchroniser.** `row` passes through a 2-flop synchroniser before any use.

**Column sequencer.**
- Dwell counter runs 0..SCAN_DIV-1.
- On wrap, col_idx advances 0→1→2→3→0.
- `col` = ~(1<<col_idx).
- `scan_tick` is high on the wrap cycle.

**Sampling.**
- Rows are sampled on the last dwell cycle of each column, after synchroniser settling.
- Within one frame (columns 0..3), the first low row found wins. Priority is lowest col_idx, then lowest row_idx. The frame result is a key k or NONE.
- Multiple simultaneous keys reduce to the single priority key; there is no ghost handling.

**Frame evaluation.** Happens on the last dwell cycle of column 3. The debounce FSM advances only on that cycle.
- IDLE
  - k → PCAND, cand=k, cnt=1.
  - NONE → IDLE.
- PCAND
  - k==cand: cnt+1.
  - cnt reaching DEBOUNCE_FRAMES → HELD, `code`=cand, `key_valid`=1, `key_press` strobe.
  - k≠cand → PCAND, cand=k, cnt=1.
  - NONE → IDLE.
- HELD
  - k==code → HELD.
  - NONE or another key → RCAND, cnt=1.
- RCAND
  - Non-matching frame: cnt+1.
  - cnt reaching DEBOUNCE_FRAMES → IDLE, `key_valid`=0, `key_release` strobe.
  - k==code → HELD, with no strobe.

**DEBOUNCE_FRAMES = 1.** The count comparison applies on the entering frame itself: PCAND/RCAND are passed through in zero frames and the accept happens immediately.

**Hold behaviour.** A second key pressed while holding is seen as a release of the first. The new key needs IDLE→PCAND afterwards. There is no auto-repeat.

**Counter widths.**
- Dwell counter: $clog2(SCAN_DIV) bits.
- Frame counter: 4 bits, saturates at DEBOUNCE_FRAMES.

## Timing

**Reset values:**
- `col`=4'b1110
- `code`=0
- `key_valid`=0
- `key_press`=0
- `key_release`=0
- `scan_tick`=0
- FSM in IDLE, all counters 0.

**Timing figures:**
- Frame length: 4*SCAN_DIV cycles.
- All outputs are registered. Strobes and `key_valid`/`code` change in the cycle after the evaluation edge.
- Press latency: DEBOUNCE_FRAMES frames, counted from the first frame in which the key is sampled. Release latency is identical.
- Row input changes reach the sampler within 2 cycles. Changes in the final 2 dwell cycles are seen in the next frame.

**Asynchronous reset mid-operation.**
- Drops all outputs to their reset values immediately.
- No `key_release` strobe is emitted.
- Scanning restarts at column 0.

## Structure

**Shared package `snake_pkg`:**
- Key code constants: KEY_LEFT=2, KEY_DOWN=3, KEY_RIGHT=4, KEY_UP=7.
- Debounce state enum: IDLE, PCAND, HELD, RCAND.

**Sub-modules:**
- `keypad_debounce_fsm`: frame result in (valid + code, eval strobe), outputs `code`/`key_valid`/`key_press`/`key_release`.
- Top level keeps the synchroniser, the column sequencer and the frame sampler.

## Test plan

All tests use SCAN_DIV=4, DEBOUNCE_FRAMES=3 (frame = 16 cycles).

- **Idle after reset:** release reset, no key → `col` cycles 1110,1101,1011,0111 every 4 clks; `scan_tick` every 4th cycle; `key_valid`=0 forever.
- **Clean press and release of key 7** (row 1, col 3) held 6 frames → `key_press` one cycle after the 3rd evaluation, `code`=7, `key_valid`=1. Release → `key_release` after 3 NONE frames, `code` stays 7.
- **Bounce:** key 4 present in frames 1 and 2, absent in frame 3, present in frames 4–6 → exactly one `key_press`, after frame 6.
- **Two keys:** keys 2 and 3 held together → `code`=2. Release 2 while holding 3 → `key_release`, then `key_press` with `code`=3 three frames after reaching IDLE.
- **Short release glitch:** key 3 HELD, 2-frame dropout → no `key_release`, `key_valid` stays 1.
- **Reset mid-operation:** assert `rst` while HELD → all outputs at reset values asynchronously; after deassert, `col`=1110 and the press is re-accepted only after 3 frames.
